// File: rtl/timer_pkg.sv
// timer_pkg
// Shared definitions for the memory-mapped countdown timer: FSM state
// encoding, register word offsets, mode constants, CTRL bit positions and
// byte-lane write helpers.
// Optional feature macro used by the timer: TIMER_PRESCALE_EN.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } state_t;

   // Register word offsets (bus address bits [3:2]).
   localparam logic [1:0] CTRL_ADDR   = 2'd0;
   localparam logic [1:0] PRESET_ADDR = 2'd1;
   localparam logic [1:0] COUNT_ADDR  = 2'd2;

   // CTRL.Mode encodings; 2'b1x behaves like one-shot.
   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   // CTRL bit positions.
   localparam logic [4:0] CTRL_EN_BIT   = 5'd0;
   localparam logic [4:0] CTRL_MODE_LSB = 5'd1;
   localparam logic [4:0] CTRL_MODE_MSB = 5'd2;
   localparam logic [4:0] CTRL_IM_BIT   = 5'd3;
   localparam logic [4:0] CTRL_PS_LSB   = 5'd8;

   // Replace only the byte lanes whose enable is set.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
      logic [31:0] merged;
      merged = old_v;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            merged[8*i +: 8] = new_v[8*i +: 8];
         end else begin
            merged[8*i +: 8] = old_v[8*i +: 8];
         end
      end
      return merged;
   endfunction

   // Single-bit version of byte_merge for sparse register fields.
   function automatic logic merge_bit(input logic        old_b,
                                      input logic [31:0] din,
                                      input logic [3:0]  be,
                                      input logic [4:0]  pos);
      return be[pos[4:3]] ? din[pos] : old_b;
   endfunction

endpackage

// File: rtl/timer_counter_if.sv
// timer_counter_if
// Bus bundle between the M-stage store/load path and the timer.
//   Addr   word select (0 CTRL, 1 PRESET, 2 COUNT, 3 unused)
//   WE     single-cycle write strobe
//   Byteen byte write enables
//   Din    lane-aligned write data
//   Dout   combinational read data
//   IRQ    level interrupt request toward HWInt
interface timer_counter_if;
   logic [1:0]  Addr;
   logic        WE;
   logic [3:0]  Byteen;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;

   modport master (output Addr, WE, Byteen, Din, input Dout, IRQ);
   modport slave  (input Addr, WE, Byteen, Din, output Dout, IRQ);
endinterface

// File: rtl/timer_prescaler.sv
// timer_prescaler
// Divides the count rate: while enabled, tick pulses once every ps+1 cycles.
// clear restarts the division so the first tick after it is ps+1 cycles away.
//   clk, reset  clock and async active-low reset
//   clear       restart the divider
//   enable      advance the divider
//   ps          divide value minus one
//   tick        count-enable pulse
// Only instantiated when TIMER_PRESCALE_EN is defined.
module timer_prescaler #(
   parameter int PS_W = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clear,
   input  logic            enable,
   input  logic [PS_W-1:0] ps,
   output logic            tick
);

   logic [PS_W-1:0] pcnt_r;

   // Tick is decoded from the registered divider so it lands on the
   // (ps+1)-th enabled cycle.
   assign tick = enable && (pcnt_r == ps);

   // Divider counter: restarts on clear and wraps after each tick.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcnt_r <= {PS_W{1'b0}};
      end else if (clear) begin
         pcnt_r <= {PS_W{1'b0}};
      end else if (enable) begin
         pcnt_r <= tick ? {PS_W{1'b0}} : pcnt_r + PS_W'(1'b1);
      end
   end

endmodule

// File: rtl/timer_counter.sv
// timer_counter
// Memory-mapped countdown timer with one-shot / auto-reload modes and an
// interrupt mask.
//   clk    system clock
//   reset  async active-low reset, clears all state
//   bus    timer_counter_if.slave: Addr/WE/Byteen/Din in, Dout/IRQ out
// Optional feature: define TIMER_PRESCALE_EN to enable the CTRL.PS field
// and the count prescaler; otherwise the count advances every cycle.
module timer_counter
   import timer_pkg::*;
#(
   parameter int PS_W = 8
) (
   input  logic           clk,
   input  logic           reset,
   timer_counter_if.slave bus
);

   state_t          state_r;
   logic            en_r;
   logic [1:0]      mode_r;
   logic            im_r;
   logic            flag_r;
   logic [31:0]     preset_r;
   logic [31:0]     count_r;

   logic            wr_s;
   logic            ctrl_wr_s;
   logic            preset_wr_s;
   logic            tick_s;
   logic [PS_W-1:0] ps_s;
   logic [31:0]     ctrl_rd_s;

   // A write needs at least one byte lane; COUNT and the unused slot never
   // disturb the FSM.
   assign wr_s        = bus.WE && (bus.Byteen != 4'b0000);
   assign ctrl_wr_s   = wr_s && (bus.Addr == CTRL_ADDR);
   assign preset_wr_s = wr_s && (bus.Addr == PRESET_ADDR);

   assign ctrl_rd_s = 32'({ps_s, 4'b0000, im_r, mode_r, en_r});

`ifdef TIMER_PRESCALE_EN
   logic [PS_W-1:0] ps_r;
   logic [PS_W-1:0] ps_new_s;

   assign ps_s = ps_r;

   // Lane-merge the prescale field from the write data.
   always_comb begin
      ps_new_s = ps_r;
      for (int i = 0; i < PS_W; i++) begin
         ps_new_s[i] = merge_bit(ps_r[i], bus.Din, bus.Byteen, CTRL_PS_LSB + 5'(i));
      end
   end

   // Prescale value register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ps_r <= {PS_W{1'b0}};
      end else if (ctrl_wr_s) begin
         ps_r <= ps_new_s;
      end
   end

   timer_prescaler #(.PS_W(PS_W)) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .clear  (state_r == LOAD),
      .enable (state_r == CNT),
      .ps     (ps_r),
      .tick   (tick_s)
   );
`else
   assign ps_s   = {PS_W{1'b0}};
   assign tick_s = 1'b1;
`endif

   // Register file and countdown FSM. A CTRL/PRESET write pre-empts every
   // internal update on the same edge (count step, flag set, En clear).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r  <= IDLE;
         en_r     <= 1'b0;
         mode_r   <= 2'b00;
         im_r     <= 1'b0;
         flag_r   <= 1'b0;
         preset_r <= 32'h0000_0000;
         count_r  <= 32'h0000_0000;
      end else begin
         if (ctrl_wr_s) begin
            en_r      <= merge_bit(en_r, bus.Din, bus.Byteen, CTRL_EN_BIT);
            mode_r[0] <= merge_bit(mode_r[0], bus.Din, bus.Byteen, CTRL_MODE_LSB);
            mode_r[1] <= merge_bit(mode_r[1], bus.Din, bus.Byteen, CTRL_MODE_MSB);
            im_r      <= merge_bit(im_r, bus.Din, bus.Byteen, CTRL_IM_BIT);
         end
         if (preset_wr_s) begin
            preset_r <= byte_merge(preset_r, bus.Din, bus.Byteen);
         end
         if (ctrl_wr_s || preset_wr_s) begin
            state_r <= IDLE;
            flag_r  <= 1'b0;
         end else begin
            case (state_r)
               IDLE: begin
                  if (en_r) begin
                     state_r <= LOAD;
                  end
               end
               LOAD: begin
                  count_r <= preset_r;
                  state_r <= CNT;
               end
               CNT: begin
                  if (!en_r) begin
                     state_r <= IDLE;
                  end else if (tick_s) begin
                     // COUNT of 1 or 0 both expire on this tick; never wrap.
                     if (count_r > 32'd1) begin
                        count_r <= count_r - 32'd1;
                     end else begin
                        count_r <= 32'd0;
                        state_r <= INT;
                        flag_r  <= 1'b1;
                     end
                  end
               end
               INT: begin
                  // Auto-reload leaves En set so IDLE restarts the period.
                  if (mode_r == MODE_RELOAD) begin
                     flag_r <= 1'b0;
                  end else begin
                     en_r <= 1'b0;
                  end
                  state_r <= IDLE;
               end
               default: begin
                  state_r <= IDLE;
               end
            endcase
         end
      end
   end

   // Zero-latency read mux for the load path.
   always_comb begin
      bus.Dout = 32'h0000_0000;
      case (bus.Addr)
         CTRL_ADDR:   bus.Dout = ctrl_rd_s;
         PRESET_ADDR: bus.Dout = preset_r;
         COUNT_ADDR:  bus.Dout = count_r;
         default:     bus.Dout = 32'h0000_0000;
      endcase
   end

   assign bus.IRQ = flag_r & im_r;

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter
// Directed-vector bench for timer_counter. Each read pushes its
// hand-computed Dout/IRQ into a scoreboard queue; a separate monitor pops
// and compares on the falling edge whenever a read is presented.
// Prescaler vectors are included when TIMER_PRESCALE_EN is defined.
module tb_timer_counter;
   import timer_pkg::*;

   typedef struct {
      string       name;
      logic [31:0] d;
      logic        irq;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic rd_strobe;
   exp_t sb_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   timer_counter_if bus();

   timer_counter #(.PS_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Expected tables, index k = reads after edge k of each test.
   int os_cnt [9]  = '{0, 0, 5, 4, 3, 2, 1, 0, 0};
   bit os_irq [9]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
   int ar_cnt [15] = '{0, 0, 3, 2, 1, 0, 0, 0, 3, 2, 1, 0, 0, 0, 3};
   bit ar_irq [15] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
   int z_ctrl [5]  = '{9, 9, 9, 9, 8};
   bit z_irq  [5]  = '{0, 0, 0, 1, 1};
   int co_cnt [7]  = '{1, 1, 4, 3, 2, 1, 0};
   bit co_irq [7]  = '{0, 0, 0, 0, 0, 0, 1};
   int im_ctrl[5]  = '{1, 1, 1, 1, 0};
   int rs_cnt [5]  = '{0, 0, 2, 1, 0};
   bit rs_irq [5]  = '{0, 0, 0, 0, 1};

   // Monitor: compare each presented read against the scoreboard head.
   initial begin
      forever begin
         @(negedge clk);
         if (rd_strobe) begin
            n_vec++;
            if (sb_q.size() == 0) begin
               n_miss++;
               $display("FAIL sb_underflow: got Dout=%h with no expected entry", bus.Dout);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               if (bus.Dout !== e.d || bus.IRQ !== e.irq) begin
                  n_miss++;
                  $display("FAIL %s: got Dout=%h IRQ=%b, want Dout=%h IRQ=%b",
                           e.name, bus.Dout, bus.IRQ, e.d, e.irq);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cyc(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
      bus.Addr   = a;
      bus.Byteen = be;
      bus.Din    = d;
      bus.WE     = 1'b1;
      step();
      bus.WE     = 1'b0;
      bus.Byteen = 4'h0;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] d, input logic irq, input string nm);
      exp_t e;
      e.name = nm;
      e.d    = d;
      e.irq  = irq;
      sb_q.push_back(e);
      bus.Addr  = a;
      rd_strobe = 1'b1;
      step();
      rd_strobe = 1'b0;
   endtask

   initial begin
      reset      = 1'b0;
      rd_strobe  = 1'b0;
      bus.Addr   = 2'd0;
      bus.WE     = 1'b0;
      bus.Byteen = 4'h0;
      bus.Din    = 32'h0;
      step();

      // Reset values on every address.
      for (int a = 0; a < 4; a++) rd(2'(a), 32'h0, 1'b0, $sformatf("reset_addr%0d", a));
      reset = 1'b1;
      step();

      // One-shot: PRESET 5, CTRL 0x9; flag at edge 7, held until CTRL write.
      wr(PRESET_ADDR, 4'hF, 32'd5);
      wr(CTRL_ADDR, 4'hF, 32'h9);
      for (int k = 0; k < 9; k++)
         rd(COUNT_ADDR, 32'(os_cnt[k]), os_irq[k], $sformatf("oneshot_k%0d", k));
      rd(CTRL_ADDR, 32'h8, 1'b1, "oneshot_ctrl_after");
      idle_cyc(5);
      rd(COUNT_ADDR, 32'h0, 1'b1, "oneshot_irq_held");
      wr(CTRL_ADDR, 4'hF, 32'h0);
      rd(CTRL_ADDR, 32'h0, 1'b0, "oneshot_irq_dropped");

      // Auto-reload: PRESET 3, CTRL 0xB; 1-cycle IRQ every 6 cycles from edge 5.
      wr(PRESET_ADDR, 4'hF, 32'd3);
      wr(CTRL_ADDR, 4'hF, 32'hB);
      for (int k = 0; k < 15; k++)
         rd(COUNT_ADDR, 32'(ar_cnt[k]), ar_irq[k], $sformatf("reload_k%0d", k));
      wr(CTRL_ADDR, 4'hF, 32'h0);

      // PRESET 0: flag at edge 3, En cleared at edge 4.
      wr(PRESET_ADDR, 4'hF, 32'd0);
      wr(CTRL_ADDR, 4'hF, 32'h9);
      for (int k = 0; k < 5; k++)
         rd(CTRL_ADDR, 32'(z_ctrl[k]), z_irq[k], $sformatf("preset0_k%0d", k));

      // Collision: CTRL write on the edge where COUNT would go 1 -> 0.
      wr(PRESET_ADDR, 4'hF, 32'd4);
      wr(CTRL_ADDR, 4'hF, 32'h9);
      idle_cyc(4);
      rd(COUNT_ADDR, 32'd2, 1'b0, "collide_pre");
      wr(CTRL_ADDR, 4'hF, 32'h9);
      for (int k = 0; k < 7; k++)
         rd(COUNT_ADDR, 32'(co_cnt[k]), co_irq[k], $sformatf("collide_k%0d", k + 6));
      wr(CTRL_ADDR, 4'hF, 32'h0);

      // Byte-lane writes, discarded CTRL bits, Byteen = 0.
      wr(PRESET_ADDR, 4'hF, 32'h1122_3344);
      wr(PRESET_ADDR, 4'b0010, 32'hFFFF_ABFF);
      rd(PRESET_ADDR, 32'h1122_AB44, 1'b0, "byte_lane1");
      wr(CTRL_ADDR, 4'hF, 32'hFFFF_FF06);
`ifdef TIMER_PRESCALE_EN
      rd(CTRL_ADDR, 32'h0000_FF06, 1'b0, "ctrl_unimpl");
`else
      rd(CTRL_ADDR, 32'h0000_0006, 1'b0, "ctrl_unimpl");
`endif
      wr(CTRL_ADDR, 4'h0, 32'h0000_0009);
`ifdef TIMER_PRESCALE_EN
      rd(CTRL_ADDR, 32'h0000_FF06, 1'b0, "ctrl_be0");
`else
      rd(CTRL_ADDR, 32'h0000_0006, 1'b0, "ctrl_be0");
`endif

      // COUNT and the unused slot are not writable and do not stop counting.
      wr(CTRL_ADDR, 4'hF, 32'h1);
      idle_cyc(2);
      wr(COUNT_ADDR, 4'hF, 32'h0);
      rd(COUNT_ADDR, 32'h1122_AB43, 1'b0, "count_ro");
      wr(2'd3, 4'hF, 32'hDEAD_BEEF);
      rd(COUNT_ADDR, 32'h1122_AB41, 1'b0, "unused_wr");
      rd(2'd3, 32'h0, 1'b0, "unused_rd");

      // IM = 0: the flag sets at edge 3 (En cleared at 4) but IRQ stays low.
      wr(CTRL_ADDR, 4'hF, 32'h0);
      wr(PRESET_ADDR, 4'hF, 32'd1);
      wr(CTRL_ADDR, 4'hF, 32'h1);
      for (int k = 0; k < 5; k++)
         rd(CTRL_ADDR, 32'(im_ctrl[k]), 1'b0, $sformatf("mask_k%0d", k));

      // Reset asserted mid-count at COUNT = 7.
      wr(PRESET_ADDR, 4'hF, 32'd20);
      wr(CTRL_ADDR, 4'hF, 32'h9);
      idle_cyc(14);
      rd(COUNT_ADDR, 32'd8, 1'b0, "midrst_pre");
      reset = 1'b0;
      rd(COUNT_ADDR, 32'h0, 1'b0, "midrst_count");
      rd(CTRL_ADDR, 32'h0, 1'b0, "midrst_ctrl");
      rd(PRESET_ADDR, 32'h0, 1'b0, "midrst_preset");
      reset = 1'b1;
      rd(COUNT_ADDR, 32'h0, 1'b0, "release_count");
      idle_cyc(3);
      rd(COUNT_ADDR, 32'h0, 1'b0, "release_idle");
      wr(PRESET_ADDR, 4'hF, 32'd2);
      wr(CTRL_ADDR, 4'hF, 32'h9);
      for (int k = 0; k < 5; k++)
         rd(COUNT_ADDR, 32'(rs_cnt[k]), rs_irq[k], $sformatf("restart_k%0d", k));

`ifdef TIMER_PRESCALE_EN
      // PS = 3: PRESET 2 flags at edge 10, PRESET 0 at edge 6.
      wr(PRESET_ADDR, 4'hF, 32'd2);
      wr(CTRL_ADDR, 4'hF, 32'h0309);
      idle_cyc(9);
      rd(COUNT_ADDR, 32'd1, 1'b0, "ps_n2_k9");
      rd(COUNT_ADDR, 32'd0, 1'b1, "ps_n2_k10");
      wr(PRESET_ADDR, 4'hF, 32'd0);
      wr(CTRL_ADDR, 4'hF, 32'h0309);
      idle_cyc(5);
      rd(COUNT_ADDR, 32'd0, 1'b0, "ps_n0_k5");
      rd(COUNT_ADDR, 32'd0, 1'b1, "ps_n0_k6");
`endif

      step();
      if (sb_q.size() != 0) begin
         n_miss++;
         $display("FAIL sb_leftover: got %0d unchecked entries, want 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
